// File: rtl/mips_muldiv_pkg.sv
// Shared types and helpers for the MIPS iterative multiply/divide unit.
package mips_muldiv_pkg;

  // Sequencer states: idle, one iteration step per cycle, sign fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Operation encoding as seen on the op_div input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Ceiling log2, used to size the step counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_muldiv_negate.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for restoring the sign of results.
module mips_muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier (and optional restoring divider) for the
// EX stage. Result is 2*WIDTH bits split into hi/lo; start/busy/done handshake.
// Optional divide support is built when MULDIV_DIV_EN is defined.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH) + 1;
`ifdef MULDIV_DIV_EN
  // The divisor magnitude is the adder operand in divide mode, so it needs
  // the extra bit that holds 2^(WIDTH-1).
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  acc;       // upper partial product / partial remainder
  logic [WIDTH-1:0] lo_reg;   // multiplier shifting out / quotient shifting in
  logic [WIDTH:0]  addend;    // multiplicand or divisor magnitude
  logic            neg_q;     // product / quotient is negative
  logic            neg_r;     // remainder is negative
  logic            done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Operand signs and magnitudes; the most-negative value needs WIDTH+1 bits.
  logic            sa, sb;
  logic [WIDTH:0]  a_mag;
  logic [BW-1:0]   b_ext, b_mag;

  assign sa = op_signed & a[WIDTH-1];
  assign sb = op_signed & b[WIDTH-1];
`ifdef MULDIV_DIV_EN
  assign b_ext = {sb, b};
`else
  assign b_ext = b;
`endif

  mips_muldiv_negate #(.WIDTH(WIDTH + 1)) u_neg_a (.neg(sa), .din({sa, a}), .dout(a_mag));
  mips_muldiv_negate #(.WIDTH(BW))        u_neg_b (.neg(sb), .din(b_ext),   .dout(b_mag));

  // One shift-add step: the sum never exceeds WIDTH+1 bits.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = acc + (lo_reg[0] ? addend : '0);

  // Sign correction of the full-width magnitude product.
  logic [2*WIDTH-1:0] prod_fix;
  mips_muldiv_negate #(.WIDTH(2 * WIDTH)) u_neg_res (
    .neg(neg_q), .din({acc[WIDTH-1:0], lo_reg}), .dout(prod_fix)
  );

`ifdef MULDIV_DIV_EN
  logic            is_div, dbz_q, dbz_out;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]  r_shift;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Restoring step: shift the next dividend bit in and try to subtract.
  assign r_shift = {acc[WIDTH-1:0], lo_reg[WIDTH-1]};
  assign diff    = {1'b0, r_shift} - {1'b0, addend};

  mips_muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (.neg(neg_q), .din(lo_reg),          .dout(quo_fix));
  mips_muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (.neg(neg_r), .din(acc[WIDTH-1:0]), .dout(rem_fix));

  assign div_by_zero = dbz_out;
`else
  logic unused_op_div;
  assign unused_op_div = op_div;
  assign div_by_zero   = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand load, iteration, and result write-back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      lo_reg <= '0;
      addend <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULDIV_DIV_EN
      is_div  <= 1'b0;
      dbz_q   <= 1'b0;
      dbz_out <= 1'b0;
      a_raw   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            acc   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
`ifdef MULDIV_DIV_EN
            is_div <= (op_div == OP_DIV);
            dbz_q  <= (op_div == OP_DIV) && (b == '0);
            a_raw  <= a;
            if (op_div == OP_DIV) begin
              addend <= b_mag;
              lo_reg <= a_mag[WIDTH-1:0];
            end else begin
              addend <= a_mag;
              lo_reg <= b_mag[WIDTH-1:0];
            end
`else
            addend <= a_mag;
            lo_reg <= b_mag;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            if (!diff[WIDTH+1]) begin
              acc    <= diff[WIDTH:0];
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc    <= r_shift;
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
            end
          end else
`endif
          {acc, lo_reg} <= {1'b0, mul_sum, lo_reg[WIDTH-1:1]};
        end
        FIX: begin
          done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
          dbz_out <= dbz_q;
          if (is_div) begin
            hi_q <= dbz_q ? a_raw : rem_fix;
            lo_q <= dbz_q ? '1    : quo_fix;
          end else
`endif
          {hi_q, lo_q} <= prod_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_mips_muldiv_unit;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dbz;
    int          acc;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  logic clock = 1'b0;
  logic reset_n;

  logic        start32, sg32, dv32, busy32, done32, dbz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sg8, dv8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, hi8, lo8;

  mips_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .start(start32), .op_signed(sg32), .op_div(dv32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32),
    .div_by_zero(dbz32)
  );

  mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .op_signed(sg8), .op_div(dv8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
    .div_by_zero(dbz8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_error(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the 32-bit instance: results, latency and busy duration.
  int busy_cnt32 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) busy_cnt32 = 0;
    else if (done32) begin
      if (q32.size() == 0) flag_error("unexpected_done32");
      else begin
        e = q32.pop_front();
        check({e.name, ".hi"}, hi32, e.hi);
        check({e.name, ".lo"}, lo32, e.lo);
        check({e.name, ".dbz"}, dbz32, e.dbz);
        check({e.name, ".latency"}, cyc - e.acc, 33);
        check({e.name, ".busy_cycles"}, busy_cnt32, 33);
      end
      busy_cnt32 = 0;
    end else if (busy32) busy_cnt32++;
  end

  // Monitor for the 8-bit instance.
  int busy_cnt8 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) busy_cnt8 = 0;
    else if (done8) begin
      if (q8.size() == 0) flag_error("unexpected_done8");
      else begin
        e = q8.pop_front();
        check({e.name, ".hi"}, hi8, e.hi);
        check({e.name, ".lo"}, lo8, e.lo);
        check({e.name, ".dbz"}, dbz8, e.dbz);
        check({e.name, ".latency"}, cyc - e.acc, 9);
        check({e.name, ".busy_cycles"}, busy_cnt8, 9);
      end
      busy_cnt8 = 0;
    end else if (busy8) busy_cnt8++;
  end

  task automatic issue32(input logic [31:0] ia, input logic [31:0] ib, input logic sg,
                         input logic dv, input logic [63:0] ehi, input logic [63:0] elo,
                         input logic edbz, input string nm, input bit expect_result = 1'b1);
    int guard = 0;
    while (busy32 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (busy32) flag_error({nm, ".idle_timeout"});
    a32 = ia; b32 = ib; sg32 = sg; dv32 = dv; start32 = 1'b1;
    if (expect_result) q32.push_back('{hi: ehi, lo: elo, dbz: edbz, acc: cyc + 1, name: nm});
    @(negedge clock);
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; {sg32, dv32} = 2'($urandom);
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic sg,
                        input logic dv, input logic [63:0] ehi, input logic [63:0] elo,
                        input logic edbz, input string nm);
    int guard = 0;
    while (busy8 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (busy8) flag_error({nm, ".idle_timeout"});
    a8 = ia; b8 = ib; sg8 = sg; dv8 = dv; start8 = 1'b1;
    q8.push_back('{hi: ehi, lo: elo, dbz: edbz, acc: cyc + 1, name: nm});
    @(negedge clock);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); {sg8, dv8} = 2'($urandom);
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (q32.size() != 0 || q8.size() != 0) flag_error({nm, ".drain_timeout"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int guard;
    reset_n = 1'b0;
    start32 = 1'b0; sg32 = 1'b0; dv32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sg8  = 1'b0; dv8  = 1'b0; a8  = '0; b8  = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset.busy32", busy32, 0);
    check("reset.done32", done32, 0);
    check("reset.hilo32", {hi32, lo32}, 0);
    check("reset.dbz32", dbz32, 0);
    check("reset.hilo8", {busy8, done8, dbz8, hi8, lo8}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Multiply vectors, WIDTH=32 (each issued as soon as the previous is done).
    issue32(32'd720, 32'd7, 1'b0, 1'b0, 64'h0, 64'd5040, 1'b0, "u720x7");
    issue32(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFF1, 1'b0, "s_m3x5");
    issue32(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 64'h4, 64'hFFFFFFF1, 1'b0, "u_fffffffdx5");
    issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE, 64'h1, 1'b0, "u_maxsq");
    issue32(32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'h40000000, 64'h0, 1'b0, "s_minsq");
    issue32(32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 64'h0, 64'h80000000, 1'b0, "s_m1xmin");
    issue32(32'd7, 32'hFFFFFFFA, 1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFD6, 1'b0, "s_7xm6");
    drain("mul32");

    // start held high: mid-run start ignored, next accepted on the done cycle.
    a32 = 32'd2; b32 = 32'd3; sg32 = 1'b0; dv32 = 1'b0; start32 = 1'b1;
    q32.push_back('{hi: 64'h0, lo: 64'd6, dbz: 1'b0, acc: cyc + 1, name: "held_2x3"});
    @(negedge clock);
    a32 = 32'd4; b32 = 32'd5;
    guard = 0;
    while (!done32 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!done32) flag_error("held.done_timeout");
    q32.push_back('{hi: 64'h0, lo: 64'd20, dbz: 1'b0, acc: cyc + 1, name: "held_4x5"});
    @(negedge clock);
    start32 = 1'b0;
    drain("held");

    // Reset in the middle of RUN discards the operation.
    issue32(32'd100, 32'd200, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, "aborted", 1'b0);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort.busy", busy32, 0);
    check("abort.done", done32, 0);
    check("abort.hi", hi32, 0);
    check("abort.lo", lo32, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue32(32'd9, 32'd9, 1'b0, 1'b0, 64'h0, 64'd81, 1'b0, "after_reset_9x9");

`ifdef MULDIV_DIV_EN
    issue32(32'd5040, 32'd7, 1'b0, 1'b1, 64'h0, 64'd720, 1'b0, "div_5040_7");
    issue32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, "div_m7_2");
    issue32(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 64'h1, 64'hFFFFFFFD, 1'b0, "div_7_m2");
    issue32(32'd123, 32'd0, 1'b0, 1'b1, 64'd123, 64'hFFFFFFFF, 1'b1, "div_123_0");
    issue32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0, 64'h80000000, 1'b0, "div_min_m1");
`else
    issue32(32'd6, 32'd7, 1'b0, 1'b1, 64'h0, 64'd42, 1'b0, "opdiv_ignored_6x7");
`endif
    drain("tail32");

    // WIDTH=8 instance.
    issue8(8'hFF, 8'hFF, 1'b0, 1'b0, 64'hFE, 64'h01, 1'b0, "w8_u_maxsq");
    issue8(8'h80, 8'h80, 1'b1, 1'b0, 64'h40, 64'h00, 1'b0, "w8_s_minsq");
    issue8(8'hFD, 8'h05, 1'b1, 1'b0, 64'hFF, 64'hF1, 1'b0, "w8_s_m3x5");
    issue8(8'hFD, 8'h05, 1'b0, 1'b0, 64'h04, 64'hF1, 1'b0, "w8_u_fdx5");
`ifdef MULDIV_DIV_EN
    issue8(8'd250, 8'd7, 1'b0, 1'b1, 64'h05, 64'h23, 1'b0, "w8_div_250_7");
    issue8(8'hF9, 8'h02, 1'b1, 1'b1, 64'hFF, 64'hFD, 1'b0, "w8_div_m7_2");
    issue8(8'h7B, 8'h00, 1'b0, 1'b1, 64'h7B, 64'hFF, 1'b1, "w8_div_123_0");
`endif
    drain("tail8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
